// File: rtl/onchip_arb_pkg.sv
// Shared constants, state encoding and small helpers for the on-chip RAM
// arbiter.
//   MEM_WORDS  : implemented RAM words; word addresses at or above are out of range
//   MAX_BURST  : largest legal burst length, longer requests are clamped
//   ADDR_W / DATA_W / BE_W / BC_W : Avalon-MM field widths
//   arb_state_t: IDLE, RD_BURST, WR_BURST
package onchip_arb_pkg;

    localparam int MEM_WORDS = 32000;
    localparam int MAX_BURST = 8;
    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int BC_W      = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } arb_state_t;

    // burstcount 0 behaves as a single beat; oversize requests are clamped.
    function automatic logic [BC_W-1:0] norm_burst(input logic [BC_W-1:0] bc);
        logic [BC_W-1:0] len;
        len = bc;
        if (bc == '0) begin
            len = BC_W'(1);
        end else if (bc > BC_W'(MAX_BURST)) begin
            len = BC_W'(MAX_BURST);
        end
        return len;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < 32'(MEM_WORDS);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
//   req    : request per port
//   last   : port that was granted most recently
//   enable : grants are only issued while high
//   gnt    : one-hot grant (all zero when disabled or nobody requests)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: the port that did not win last time goes first.
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters
// (port 0 = Nios data master, port 1 = DMA). Round-robin grant in IDLE,
// locked fixed-length bursts, per-port readdatavalid routing and
// suppression of beats that fall outside the implemented RAM.
//   clk, reset_n               : clock, asynchronous active-low reset
//   pN_address/byteenable/read/write/writedata/burstcount : master commands
//   pN_waitrequest             : low only in the cycle a command/beat is taken
//   pN_readdata/readdatavalid  : read return, one registered pulse per word
//   mem_*                      : RAM side; mem_readdata is valid one cycle
//                                after its address was presented
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [BE_W-1:0]   p0_byteenable,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [DATA_W-1:0] p0_writedata,
    input  logic [BC_W-1:0]   p0_burstcount,
    output logic              p0_waitrequest,
    output logic [DATA_W-1:0] p0_readdata,
    output logic              p0_readdatavalid,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [BE_W-1:0]   p1_byteenable,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [DATA_W-1:0] p1_writedata,
    input  logic [BC_W-1:0]   p1_burstcount,
    output logic              p1_waitrequest,
    output logic [DATA_W-1:0] p1_readdata,
    output logic              p1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    // Per-port views so the datapath can be indexed by port number.
    logic [ADDR_W-1:0] p_addr [2];
    logic [BE_W-1:0]   p_be   [2];
    logic [DATA_W-1:0] p_wd   [2];
    logic [BC_W-1:0]   p_bc   [2];
    logic [1:0]        p_rd;
    logic [1:0]        p_wr;
    logic [1:0]        req;

    assign p_addr[0] = p0_address;
    assign p_addr[1] = p1_address;
    assign p_be[0]   = p0_byteenable;
    assign p_be[1]   = p1_byteenable;
    assign p_wd[0]   = p0_writedata;
    assign p_wd[1]   = p1_writedata;
    assign p_bc[0]   = p0_burstcount;
    assign p_bc[1]   = p1_burstcount;
    assign p_rd      = {p1_read, p0_read};
    assign p_wr      = {p1_write, p0_write};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req[gi] = p_rd[gi] | p_wr[gi];
        end
    endgenerate

    arb_state_t        state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              rr_last_reg, rr_last_next;
    logic [ADDR_W-1:0] beat_addr_reg, beat_addr_next;
    logic [BC_W-1:0]   beats_left_reg, beats_left_next;
    // Set once a burst has touched an out-of-range word, so a burst that
    // runs off the top of the address space never wraps back into RAM.
    logic              burst_oor_reg, burst_oor_next;
    logic [1:0]        rv_port_reg, rv_port_next;
    logic              rv_zero_reg, rv_zero_next;

    logic              arb_enable;
    logic [1:0]        gnt;
    logic [1:0]        accept;
    logic              sel;
    logic              issue_rd;
    logic              issue_wr;
    logic              issue_oor;
    logic [ADDR_W-1:0] issue_addr;
    logic [BC_W-1:0]   burst_len;

    // reset_n gates the grant so both masters see waitrequest while reset
    // is asserted.
    assign arb_enable = (state_reg == IDLE) && reset_n;

    rr_arb2 u_rr_arb2 (
        .req    (req),
        .last   (rr_last_reg),
        .enable (arb_enable),
        .gnt    (gnt)
    );

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        rr_last_next    = rr_last_reg;
        beat_addr_next  = beat_addr_reg;
        beats_left_next = beats_left_reg;
        burst_oor_next  = burst_oor_reg;
        accept          = 2'b00;
        sel             = owner_reg;
        issue_rd        = 1'b0;
        issue_wr        = 1'b0;
        issue_addr      = beat_addr_reg;
        issue_oor       = burst_oor_reg | ~in_range(beat_addr_reg);
        burst_len       = '0;

        case (state_reg)
            IDLE: begin
                if (|gnt) begin
                    sel          = gnt[1];
                    accept[sel]  = 1'b1;
                    issue_rd     = p_rd[sel];
                    issue_wr     = p_wr[sel];
                    issue_addr   = p_addr[sel];
                    issue_oor    = ~in_range(p_addr[sel]);
                    owner_next   = sel;
                    rr_last_next = sel;
                    burst_len    = norm_burst(p_bc[sel]);
                    if (burst_len > BC_W'(1)) begin
                        state_next      = p_wr[sel] ? WR_BURST : RD_BURST;
                        beat_addr_next  = p_addr[sel] + ADDR_W'(1);
                        beats_left_next = burst_len - BC_W'(1);
                        burst_oor_next  = issue_oor;
                    end
                end
            end
            RD_BURST: begin
                issue_rd        = 1'b1;
                beat_addr_next  = beat_addr_reg + ADDR_W'(1);
                beats_left_next = beats_left_reg - BC_W'(1);
                burst_oor_next  = issue_oor;
                if (beats_left_reg == BC_W'(1)) begin
                    state_next = IDLE;
                end
            end
            WR_BURST: begin
                // Owner may stall between beats; the address comes from
                // beat_addr, never from the requester.
                if (p_wr[owner_reg]) begin
                    accept[owner_reg] = 1'b1;
                    issue_wr          = 1'b1;
                    beat_addr_next    = beat_addr_reg + ADDR_W'(1);
                    beats_left_next   = beats_left_reg - BC_W'(1);
                    burst_oor_next    = issue_oor;
                    if (beats_left_reg == BC_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Out-of-range read beats still return a word, zeroed via rv_zero.
    assign rv_port_next = issue_rd ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign rv_zero_next = issue_rd & issue_oor;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            rr_last_reg    <= 1'b1;
            beat_addr_reg  <= '0;
            beats_left_reg <= '0;
            burst_oor_reg  <= 1'b0;
            rv_port_reg    <= 2'b00;
            rv_zero_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            rr_last_reg    <= rr_last_next;
            beat_addr_reg  <= beat_addr_next;
            beats_left_reg <= beats_left_next;
            burst_oor_reg  <= burst_oor_next;
            rv_port_reg    <= rv_port_next;
            rv_zero_reg    <= rv_zero_next;
        end
    end

    assign mem_address    = issue_addr;
    assign mem_byteenable = p_be[sel];
    assign mem_writedata  = p_wd[sel];
    assign mem_chipselect = (issue_rd | issue_wr) & ~issue_oor;
    assign mem_write      = issue_wr & ~issue_oor;
    assign mem_clken      = 1'b1;

    assign p0_waitrequest   = ~accept[0];
    assign p1_waitrequest   = ~accept[1];
    assign p0_readdatavalid = rv_port_reg[0];
    assign p1_readdatavalid = rv_port_reg[1];
    assign p0_readdata      = rv_zero_reg ? '0 : mem_readdata;
    assign p1_readdata      = rv_zero_reg ? '0 : mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;

    localparam int NWORDS = 32000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] a_d  [2];
    logic [3:0]  be_d [2];
    logic [31:0] wd_d [2];
    logic [3:0]  bc_d [2];
    logic [1:0]  rd_d, wr_d;
    logic [1:0]  wreq, rdv;
    logic [31:0] rdata [2];
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    logic [31:0] ram     [0:32767];
    logic [31:0] ref_mem [0:32767];
    int          checks = 0;
    int          errors = 0;
    int          oor_hits = 0;
    bit          model_last;

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .p0_address       (a_d[0]),
        .p0_byteenable    (be_d[0]),
        .p0_read          (rd_d[0]),
        .p0_write         (wr_d[0]),
        .p0_writedata     (wd_d[0]),
        .p0_burstcount    (bc_d[0]),
        .p0_waitrequest   (wreq[0]),
        .p0_readdata      (rdata[0]),
        .p0_readdatavalid (rdv[0]),
        .p1_address       (a_d[1]),
        .p1_byteenable    (be_d[1]),
        .p1_read          (rd_d[1]),
        .p1_write         (wr_d[1]),
        .p1_writedata     (wd_d[1]),
        .p1_burstcount    (bc_d[1]),
        .p1_waitrequest   (wreq[1]),
        .p1_readdata      (rdata[1]),
        .p1_readdatavalid (rdv[1]),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // RAM with registered address: q is valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    always @(posedge clk) begin
        if (mem_chipselect && 32'(mem_address) >= NWORDS) oor_hits <= oor_hits + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        return (a < NWORDS) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic wait_accept(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!wreq[p]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(ok), 32'd1);
    endtask

    // One transaction of any length on one port; checks RAM-side beats for
    // writes and the returned word stream for reads against ref_mem.
    task automatic run_burst(input int p, input bit wr, input int addr, input logic [3:0] bc,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input int gap_beat, input int gap_len, output logic [31:0] first_rd);
        int  len;
        bit  ok;
        len = (bc == 0) ? 1 : ((bc > 8) ? 8 : int'(bc));
        first_rd = 32'h0;
        @(negedge clk);
        a_d[p] = addr[14:0]; be_d[p] = be; bc_d[p] = bc; wd_d[p] = wdata;
        if (wr) wr_d[p] = 1'b1; else rd_d[p] = 1'b1;
        for (int k = 0; k < len; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == gap_beat) begin
                    wr_d[p] = 1'b0;
                    for (int g = 0; g < gap_len; g++) begin
                        #1;
                        check("gap_wait", 32'(wreq[p]), 32'd1);
                        @(negedge clk);
                    end
                end
                wr_d[p] = 1'b1;
                wd_d[p] = wdata + 32'(k);
                a_d[p]  = 15'($urandom_range(0, 32767));
            end
            wait_accept(p, ok);
            if (wr) begin
                check("wr_cs", 32'(mem_chipselect), 32'(addr + k < NWORDS));
                if (addr + k < NWORDS) begin
                    check("wr_addr", 32'(mem_address), 32'(addr + k));
                    check("wr_data", mem_writedata, wdata + 32'(k));
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[addr + k][b*8 +: 8] = (wdata + 32'(k)) >> (b*8);
                end
            end
            if (k == 0) model_last = p[0];
            @(posedge clk);
            if (!wr) break;
        end
        if (wr) begin
            @(negedge clk);
            wr_d[p] = 1'b0;
        end else begin
            for (int c = 0; c < len + 2; c++) begin
                @(negedge clk);
                if (c == 0) rd_d[p] = 1'b0;
                check("rv_pulse", 32'(rdv[p]), 32'(c < len));
                check("rv_other", 32'(rdv[1-p]), 32'd0);
                if (c < len) begin
                    check("rd_data", rdata[p], exp_word(addr + c));
                    if (c == 0) first_rd = rdata[p];
                end
            end
        end
    endtask

    typedef struct {
        int          port;
        bit          wr;
        int          addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] rd;
    int          g, gprev, n0, n1, mism;
    int          cnt [2];
    logic [14:0] aprev;

    initial begin
        reset_n = 1'b0;
        rd_d = 2'b00; wr_d = 2'b00;
        for (int p = 0; p < 2; p++) begin
            a_d[p] = '0; be_d[p] = 4'hF; wd_d[p] = '0; bc_d[p] = 4'd1;
        end
        for (int i = 0; i < 32768; i++) begin
            ram[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        model_last = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_waitreq", 32'(wreq), 32'b11);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_rv", 32'(rdv), 32'd0);
        check("clken", 32'(mem_clken), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Both ports read every cycle: grants must alternate from port 0.
        n0 = 0; n1 = 0; cnt[0] = 0; cnt[1] = 0; gprev = 0; aprev = '0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check("alt_rv", 32'(rdv), 32'(2'b01 << gprev));
                check("alt_data", rdata[gprev], exp_word(int'(aprev)));
                if (rdv[0]) cnt[0]++;
                if (rdv[1]) cnt[1]++;
            end
            if (c < 8) begin
                rd_d = 2'b11; bc_d[0] = 4'd1; bc_d[1] = 4'd1;
                a_d[0] = 15'(16'h0040 + n0); a_d[1] = 15'(16'h0080 + n1);
                #1;
                g = model_last ? 0 : 1;
                check("alt_grant", 32'(wreq), 32'(~(2'b01 << g) & 2'b11));
                model_last = g[0];
                gprev = g;
                aprev = a_d[g];
                if (g == 0) n0++; else n1++;
            end else begin
                rd_d = 2'b00;
            end
        end
        check("alt_cnt0", 32'(cnt[0]), 32'd4);
        check("alt_cnt1", 32'(cnt[1]), 32'd4);

        // Single-beat vectors.
        vecs[0] = '{0, 1'b1, 'h0010, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 1'b0, 'h0010, 4'hF, 32'h0, 32'hDEADBEEF};
        vecs[2] = '{1, 1'b1, 'h0020, 4'hF, 32'h11223344, 32'h0};
        vecs[3] = '{0, 1'b1, 'h0020, 4'b0101, 32'hAABBCCDD, 32'h0};
        vecs[4] = '{1, 1'b0, 'h0020, 4'hF, 32'h0, 32'h11BB33DD};
        vecs[5] = '{1, 1'b1, 'h7D05, 4'hF, 32'h12345678, 32'h0};
        vecs[6] = '{0, 1'b0, 'h7D05, 4'hF, 32'h0, 32'h0};
        vecs[7] = '{1, 1'b0, 'h7FFF, 4'hF, 32'h0, 32'h0};
        vecs[8] = '{0, 1'b0, 'h7CFF, 4'hF, 32'h0, pat('h7CFF)};
        for (int i = 0; i < 9; i++) begin
            run_burst(vecs[i].port, vecs[i].wr, vecs[i].addr, 4'd1, vecs[i].be,
                      vecs[i].wdata, 0, 0, rd);
            if (!vecs[i].wr) check($sformatf("vec%0d", i), rd, vecs[i].exp_rd);
        end

        // Port 1 read burst of 8 while port 0 waits.
        run_burst(0, 1'b0, 'h0005, 4'd1, 4'hF, 32'h0, 0, 0, rd);
        @(negedge clk);
        rd_d = 2'b11; a_d[1] = 15'h0100; bc_d[1] = 4'd8; a_d[0] = 15'h0200; bc_d[0] = 4'd1;
        #1;
        check("b8_grant", 32'(wreq), 32'b01);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) rd_d[1] = 1'b0;
            check("b8_rv", 32'(rdv), 32'b10);
            check("b8_data", rdata[1], exp_word('h0100 + k - 1));
            #1;
            check("b8_wait0", 32'(wreq[0]), 32'(k != 8));
        end
        @(negedge clk);
        rd_d = 2'b00;
        check("b8_p0_rv", 32'(rdv), 32'b01);
        check("b8_p0_data", rdata[0], exp_word('h0200));
        bc_d[1] = 4'd1;
        model_last = 1'b0;

        // Write burst over the top of RAM with a 2-cycle stall.
        run_burst(0, 1'b1, 'h7CFE, 4'd4, 4'hF, 32'hC0DE0000, 2, 2, rd);
        check("wb_ram0", ram['h7CFE], 32'hC0DE0000);
        check("wb_ram1", ram['h7CFF], 32'hC0DE0001);
        run_burst(1, 1'b0, 'h7D00, 4'd1, 4'hF, 32'h0, 0, 0, rd);
        check("wb_rd7d00", rd, 32'h0);

        // Reset in the middle of a 6-beat read burst.
        @(negedge clk);
        rd_d[0] = 1'b1; a_d[0] = 15'h0300; bc_d[0] = 4'd6;
        #1;
        check("rb_accept", 32'(wreq[0]), 32'd0);
        @(negedge clk);
        rd_d[0] = 1'b0; bc_d[0] = 4'd1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        model_last = 1'b1;
        #1;
        check("rb_rst_rv", 32'(rdv), 32'd0);
        check("rb_rst_wait", 32'(wreq), 32'b11);
        check("rb_rst_cs", 32'(mem_chipselect), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rb_no_rv", 32'(rdv), 32'd0);
        end
        rd_d = 2'b11; a_d[0] = 15'h0011; a_d[1] = 15'h0012;
        #1;
        check("rb_first_grant", 32'(wreq), 32'b10);
        model_last = 1'b0;
        @(negedge clk);
        rd_d = 2'b00;
        check("rb_post_rv", 32'(rdv), 32'b01);
        check("rb_post_data", rdata[0], exp_word('h0011));

        // Randomized single-port traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            int p, a;
            p = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       a = int'($urandom_range(0, 63));
                1:       a = int'($urandom_range(31990, 32010));
                default: a = int'($urandom_range(32760, 32767));
            endcase
            run_burst(p, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
                      4'($urandom_range(1, 15)), $urandom,
                      int'($urandom_range(1, 8)), int'($urandom_range(0, 2)), rd);
        end

        mism = 0;
        for (int i = 0; i < 32768; i++) if (ram[i] !== ref_mem[i]) mism++;
        check("ram_vs_ref", 32'(mism), 32'd0);
        check("oor_hits", 32'(oor_hits), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
